// File: rtl/nibble_serializer.sv
// Serializes WIDTH-bit words, LSB- or MSB-first per word, into a free-running downstream shift register.
// First bit one cycle after accept when idle; back-to-back words with no gap; 2-entry input FIFO gates s_ready.
module nibble_serializer #(
  parameter int WIDTH    = 4,
  parameter bit IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_dir,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             ser_out,
  output logic             dir_out,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] sreg;

  // Each entry carries {dir, data}.
  logic [WIDTH:0]   mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  logic             push;
  logic             pop;
  logic [WIDTH:0]   head;

  assign s_ready = (count != 2'd2);
  assign push    = s_valid && s_ready;
  assign head    = mem[rd_ptr];
  assign pop     = (count != 2'd0) && ((state == IDLE) || (bit_cnt == LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {s_dir, s_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The first bit is driven straight from the popped entry; sreg holds the remaining bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      sreg      <= '0;
      ser_out   <= IDLE_BIT;
      dir_out   <= 1'b0;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= (state == SHIFT) && (bit_cnt == LAST);
      if (pop) begin
        state   <= SHIFT;
        busy    <= 1'b1;
        bit_cnt <= '0;
        dir_out <= head[WIDTH];
        if (head[WIDTH]) begin
          ser_out <= head[0];
          sreg    <= head[WIDTH-1:0] >> 1;
        end else begin
          ser_out <= head[WIDTH-1];
          sreg    <= head[WIDTH-1:0] << 1;
        end
      end else if (state == SHIFT) begin
        if (bit_cnt == LAST) begin
          state   <= IDLE;
          busy    <= 1'b0;
          bit_cnt <= '0;
          ser_out <= IDLE_BIT;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
          if (dir_out) begin
            ser_out <= sreg[0];
            sreg    <= sreg >> 1;
          end else begin
            ser_out <= sreg[WIDTH-1];
            sreg    <= sreg << 1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer with a downstream shift register attached and a word-level reference model.
module tb_nibble_serializer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] s_data;
  logic         s_dir;
  logic         s_valid;
  logic         s_ready;
  logic         ser_out;
  logic         dir_out;
  logic         busy;
  logic         word_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  nibble_serializer #(.WIDTH(W), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_dir(s_dir), .s_valid(s_valid),
    .s_ready(s_ready), .ser_out(ser_out), .dir_out(dir_out), .busy(busy), .word_done(word_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Downstream bidirectional register: free-running, steered by dir_out.
  logic [W-1:0] ds = '0;
  always @(posedge clk) begin
    if (dir_out) ds <= {ser_out, ds[W-1:1]};
    else         ds <= {ds[W-2:0], ser_out};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the active word and its bit index.
  logic [W:0]   mq[$];
  logic [W:0]   cur;
  int           idx = -1;
  logic         exp_dir = 1'b0;
  logic         exp_done = 1'b0;
  logic [W-1:0] done_word = '0;
  logic         do_push;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      idx      = -1;
      exp_dir  = 1'b0;
      exp_done = 1'b0;
    end else begin
      do_push  = s_valid && (mq.size() < 2);
      exp_done = (idx == W - 1);
      if (idx == W - 1) done_word = cur[W-1:0];
      if (idx >= 0 && idx < W - 1) idx++;
      else if (mq.size() > 0) begin
        cur     = mq.pop_front();
        idx     = 0;
        exp_dir = cur[W];
      end else idx = -1;
      if (do_push) mq.push_back({s_dir, s_data});
    end
  end

  // Per-cycle comparison plus trace logging for the directed checks.
  logic         ser_q[$];
  logic [W-1:0] done_q[$];
  int           done_cyc[$];

  always @(negedge clk) begin
    if (!rst) begin
      check("s_ready", s_ready, (mq.size() < 2));
      check("busy", busy, (idx >= 0));
      check("ser_out", ser_out, (idx < 0) ? 1'b0 : (exp_dir ? cur[idx] : cur[W-1-idx]));
      check("dir_out", dir_out, exp_dir);
      check("word_done", word_done, exp_done);
      if (exp_done) check("downstream_at_done", ds, done_word);
      if (busy) ser_q.push_back(ser_out);
      if (word_done) begin
        done_q.push_back(ds);
        done_cyc.push_back(cyc);
      end
    end
  end

  task automatic clear_logs();
    ser_q.delete();
    done_q.delete();
    done_cyc.delete();
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge with s_valid still high.
  task automatic push_word(input logic [W-1:0] d, input logic dr, output int stalls);
    s_data  = d;
    s_dir   = dr;
    s_valid = 1'b1;
    stalls  = 0;
    while (!s_ready && stalls < 20) begin
      @(negedge clk);
      stalls++;
    end
    if (!s_ready) check("push_timeout", 0, 1);
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  function automatic logic [W-1:0] ser_seq();
    logic [W-1:0] v = '0;
    for (int i = 0; i < ser_q.size() && i < W; i++) v = {v[W-2:0], ser_q[i]};
    return v;
  endfunction

  int st;
  int a;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_dir = 1'b0;
    #2;
    check("rst_s_ready", s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_ser_out", ser_out, 0);
    check("rst_dir_out", dir_out, 0);
    check("rst_word_done", word_done, 0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Single word, LSB first.
    clear_logs();
    push_word(4'b1011, 1'b1, st);
    a = acc_cyc;
    s_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("s1_nbits", ser_q.size(), 4);
    check("s1_ser_seq", ser_seq(), 4'b1101);
    check("s1_ndone", done_q.size(), 1);
    if (done_q.size() > 0) begin
      check("s1_downstream", done_q[0], 4'b1011);
      check("s1_latency", done_cyc[0] - a, W + 1);
    end
    check("s1_idle_dir_hold", dir_out, 1);
    check("s1_idle_ser", ser_out, 0);
    check("s1_idle_busy", busy, 0);
    check("s1_idle_ready", s_ready, 1);

    // Single word, MSB first.
    clear_logs();
    push_word(4'b1011, 1'b0, st);
    s_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("s2_ser_seq", ser_seq(), 4'b1011);
    check("s2_ndone", done_q.size(), 1);
    if (done_q.size() > 0) check("s2_downstream", done_q[0], 4'b1011);
    check("s2_idle_dir", dir_out, 0);

    // Back-to-back words, then a fourth offered while full.
    clear_logs();
    push_word(4'hA, 1'b1, st);
    push_word(4'h5, 1'b0, st);
    push_word(4'hC, 1'b1, st);
    check("s3_ready_full", s_ready, 0);
    push_word(4'h6, 1'b0, st);
    check("s4_stall_cycles", st, 3);
    s_valid = 1'b0;
    repeat (25) @(negedge clk);
    check("s3_nbits", ser_q.size(), 16);
    check("s3_ndone", done_q.size(), 4);
    if (done_q.size() == 4) begin
      check("s3_done0", done_q[0], 4'hA);
      check("s3_done1", done_q[1], 4'h5);
      check("s3_done2", done_q[2], 4'hC);
      check("s3_done3", done_q[3], 4'h6);
      for (int i = 1; i < 4; i++) check("s3_done_spacing", done_cyc[i] - done_cyc[i-1], W);
    end

    // Reset during bit 2 of 4'hF with one word queued.
    clear_logs();
    push_word(4'hF, 1'b1, st);
    push_word(4'h3, 1'b0, st);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("s5_rst_ser", ser_out, 0);
    check("s5_rst_busy", busy, 0);
    check("s5_rst_dir", dir_out, 0);
    check("s5_rst_done", word_done, 0);
    check("s5_rst_ready", s_ready, 1);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("s5_nbits_before_rst", ser_q.size(), 3);
    check("s5_ndone", done_q.size(), 0);
    check("s5_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
